// File: rtl/dm_sba_ctrl.sv
// dm_sba_ctrl: System Bus Access manager for the RISC-V debug module.
// Owns sbcs/sbaddress0/sbdata0 and runs single-beat 32-bit bus accesses.
// Ports: clk, rst (sync, active-high); dmi_valid/write/addr/wdata/rdata;
// bus_req/we/addr/wdata/be out, bus_gnt/rvalid/rdata/err in; sb_busy.
// Optional: define SBA_TIMEOUT_EN to enable the response timeout counter.
module dm_sba_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi_valid,
  input  logic        dmi_write,
  input  logic [7:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] dmi_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        sb_busy
);

  typedef enum logic [2:0] {
    sbv_0_draft = 3'd0,
    sbv_1_0     = 3'd1
  } sb_ver_e;

  typedef enum logic [2:0] {
    sbe_none      = 3'd0,
    sbe_timeout   = 3'd1,
    sberr_address = 3'd2,
    sbe_alignment = 3'd3,
    sbe_size      = 3'd4,
    sbe_other     = 3'd7
  } sb_err_e;

  typedef enum logic [2:0] {
    sba_8bit   = 3'd0,
    sba_16bit  = 3'd1,
    sba_32bit  = 3'd2,
    sba_64bit  = 3'd3,
    sba_128bit = 3'd4
  } sb_acc_e;

  typedef struct packed {
    logic [2:0] version;
    logic [5:0] rsvd;
    logic       busyerror;
    logic       busy;
    logic       readonaddr;
    logic [2:0] access;
    logic       autoincrement;
    logic       readondata;
    logic [2:0] error;
    logic [6:0] asize;
    logic       access128;
    logic       access64;
    logic       access32;
    logic       access16;
    logic       access8;
  } sbcs_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] sbaddress0;
  logic [31:0] sbdata0;
  logic        busyerror;
  logic        readonaddr;
  logic        autoincrement;
  logic        readondata;
  logic [2:0]  access;
  logic [2:0]  error;
  logic [1:0]  txn_size;

  logic        busy;
  logic        sel_cs;
  logic        sel_addr;
  logic        sel_data;
  logic        errs_clear;
  logic        want_rd;
  logic        want_wr;
  logic        size_bad;
  logic        align_bad;
  logic        start;
  logic        start_err;
  logic [31:0] start_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        done;
  logic        tmo;
  logic        tlim_hit;
  sbcs_t       sbcs_rd;

  assign busy    = (state != IDLE);
  assign sb_busy = busy;

  assign sel_cs   = dmi_valid && (dmi_addr == 8'h38);
  assign sel_addr = dmi_valid && (dmi_addr == 8'h39);
  assign sel_data = dmi_valid && (dmi_addr == 8'h3c);

  assign errs_clear = !busyerror && (error == sbe_none);

  // An sbaddress0 write checks alignment against the new address.
  assign start_addr = (sel_addr && dmi_write) ? dmi_wdata : sbaddress0;

  assign want_rd = !busy && errs_clear &&
                   ((sel_addr && dmi_write && readonaddr) ||
                    (sel_data && !dmi_write && readondata));
  assign want_wr = !busy && errs_clear && sel_data && dmi_write;

  assign size_bad  = (access > sba_32bit);
  assign align_bad = ((access == sba_16bit) && start_addr[0]) ||
                     ((access == sba_32bit) && (start_addr[1:0] != 2'b00));

  assign start     = (want_rd || want_wr) && !size_bad && !align_bad;
  assign start_err = (want_rd || want_wr) && (size_bad || align_bad);

  always_comb begin
    lane_be    = 4'hf;
    lane_wdata = dmi_wdata;
    case (access)
      sba_8bit: begin
        lane_be    = 4'b0001 << start_addr[1:0];
        lane_wdata = {4{dmi_wdata[7:0]}};
      end
      sba_16bit: begin
        lane_be    = 4'b0011 << start_addr[1:0];
        lane_wdata = {2{dmi_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_shift = bus_rdata >> {bus_addr[1:0], 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    case (txn_size)
      2'd0:    rd_ext = {24'd0, rd_shift[7:0]};
      2'd1:    rd_ext = {16'd0, rd_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    sbcs_rd               = '0;
    sbcs_rd.version       = sbv_1_0;
    sbcs_rd.busyerror     = busyerror;
    sbcs_rd.busy          = busy;
    sbcs_rd.readonaddr    = readonaddr;
    sbcs_rd.access        = access;
    sbcs_rd.autoincrement = autoincrement;
    sbcs_rd.readondata    = readondata;
    sbcs_rd.error         = error;
    sbcs_rd.asize         = 7'd32;
    sbcs_rd.access32      = 1'b1;
    sbcs_rd.access16      = 1'b1;
    sbcs_rd.access8       = 1'b1;
  end

  always_comb begin
    dmi_rdata = '0;
    case (dmi_addr)
      8'h38:   dmi_rdata = sbcs_rd;
      8'h39:   dmi_rdata = sbaddress0;
      8'h3c:   dmi_rdata = sbdata0;
      default: ;
    endcase
  end

`ifdef SBA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tcnt;

  // tcnt holds the number of cycles already spent in REQ/RESP.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tcnt <= '0;
    else                      tcnt <= tcnt + CW'(1);
  end

  assign tlim_hit = (tcnt >= TLIM);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tlim_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = RESP;
        end else if (tlim_hit) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tlim_hit) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbaddress0    <= '0;
      sbdata0       <= '0;
      busyerror     <= 1'b0;
      readonaddr    <= 1'b0;
      access        <= sba_8bit;
      autoincrement <= 1'b0;
      readondata    <= 1'b0;
      error         <= sbe_none;
      txn_size      <= 2'd0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_be        <= '0;
    end else begin
      if (sel_cs && dmi_write) begin
        busyerror     <= busyerror & ~dmi_wdata[22];
        readonaddr    <= dmi_wdata[20];
        access        <= dmi_wdata[19:17];
        autoincrement <= dmi_wdata[16];
        readondata    <= dmi_wdata[15];
        error         <= error & ~dmi_wdata[14:12];
      end
      if ((sel_addr || sel_data) && busy) busyerror <= 1'b1;
      if (sel_addr && dmi_write && !busy) sbaddress0 <= dmi_wdata;
      if (sel_data && dmi_write && !busy) sbdata0 <= dmi_wdata;
      if (start_err) error <= size_bad ? sbe_size : sbe_alignment;
      if (start) begin
        bus_we    <= want_wr;
        bus_addr  <= start_addr;
        bus_wdata <= lane_wdata;
        bus_be    <= lane_be;
        txn_size  <= access[1:0];
      end
      // Completion and timeout come last so they beat a same-cycle W1C.
      if (done) begin
        if (bus_err) begin
          error <= sberr_address;
        end else begin
          if (!bus_we) sbdata0 <= rd_ext;
          if (autoincrement) sbaddress0 <= sbaddress0 + (32'd1 << txn_size);
        end
      end
      if (tmo) error <= sbe_timeout;
    end
  end

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// tb_dm_sba_ctrl: directed bench for dm_sba_ctrl with a bus responder
// and a queue of expected bus transactions.
module tb_dm_sba_ctrl;

  localparam logic [7:0] A_CS   = 8'h38;
  localparam logic [7:0] A_ADDR = 8'h39;
  localparam logic [7:0] A_DATA = 8'h3c;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmi_valid;
  logic        dmi_write;
  logic [7:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        sb_busy;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t exp_q[$];

  int          total = 0;
  int          bad = 0;
  logic        gnt_en = 1'b0;
  logic        rsp_err = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_pend = 1'b0;

  always #5 clk = ~clk;

  dm_sba_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmi_valid  (dmi_valid),
    .dmi_write  (dmi_write),
    .dmi_addr   (dmi_addr),
    .dmi_wdata  (dmi_wdata),
    .dmi_rdata  (dmi_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err),
    .sb_busy    (sb_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dmi_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    dmi_valid = 1'b1;
    dmi_write = 1'b1;
    dmi_addr  = a;
    dmi_wdata = d;
    @(negedge clk);
    dmi_valid = 1'b0;
    dmi_write = 1'b0;
  endtask

  task automatic dmi_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    dmi_valid = 1'b1;
    dmi_write = 1'b0;
    dmi_addr  = a;
    #1 d = dmi_rdata;
    @(negedge clk);
    dmi_valid = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    dmi_valid = 1'b0;
    dmi_addr  = a;
    #1 d = dmi_rdata;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (sb_busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, {31'd0, sb_busy}, 32'd0);
  endtask

  task automatic no_req(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_req) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic push(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    txn_t t;
    t.we    = we;
    t.addr  = a;
    t.wdata = wd;
    t.be    = be;
    exp_q.push_back(t);
  endtask

  // Bus responder: grant on request, answer one cycle later.
  initial begin
    txn_t t;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = '0;
    forever begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_err    = 1'b0;
      if (rsp_pend) begin
        bus_rvalid = 1'b1;
        bus_err    = rsp_err;
        bus_rdata  = rsp_data;
        rsp_pend   = 1'b0;
      end
      bus_gnt = bus_req && gnt_en;
      if (bus_gnt) begin
        if (exp_q.size() == 0) begin
          chk("queue_at_gnt", exp_q.size(), 1);
        end else begin
          t = exp_q.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, t.we});
          chk("bus_addr", bus_addr, t.addr);
          chk("bus_be", {28'd0, bus_be}, {28'd0, t.be});
          if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
        end
        rsp_pend = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          cyc;

    rst       = 1'b1;
    dmi_valid = 1'b0;
    dmi_write = 1'b0;
    dmi_addr  = '0;
    dmi_wdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", {31'd0, sb_busy}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_baddr", bus_addr, 32'd0);
    chk("rst_bwdata", bus_wdata, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    peek(A_CS, v);
    chk("rst_sbcs", v, 32'h2000_0407);
    peek(A_ADDR, v);
    chk("rst_sbaddr", v, 32'd0);
    peek(A_DATA, v);
    chk("rst_sbdata", v, 32'd0);
    peek(8'h3d, v);
    chk("undecoded", v, 32'd0);
    rst = 1'b0;

    // 32-bit read on address write
    gnt_en   = 1'b1;
    rsp_data = 32'hDEAD_BEEF;
    dmi_wr(A_CS, 32'h0014_0000);
    push(1'b0, 32'h1000, 32'd0, 4'hf);
    dmi_wr(A_ADDR, 32'h1000);
    wait_idle("rd32_idle", cyc);
    chk("rd32_latency", cyc + 1, 3);
    peek(A_DATA, v);
    chk("rd32_data", v, 32'hDEAD_BEEF);
    peek(A_ADDR, v);
    chk("rd32_addr", v, 32'h1000);
    peek(A_CS, v);
    chk("rd32_sbcs", v, 32'h2014_0407);

    // 8-bit write with auto-increment
    dmi_wr(A_CS, 32'h0001_0000);
    dmi_wr(A_ADDR, 32'h2003);
    push(1'b1, 32'h2003, 32'hA5A5_A5A5, 4'b1000);
    dmi_wr(A_DATA, 32'hA5);
    wait_idle("wr8_idle", cyc);
    peek(A_ADDR, v);
    chk("wr8_addr_inc", v, 32'h2004);
    peek(A_DATA, v);
    chk("wr8_data", v, 32'hA5);

    // misaligned 16-bit read
    dmi_wr(A_CS, 32'h0012_0000);
    dmi_wr(A_ADDR, 32'h3001);
    no_req("align_noreq", 4);
    peek(A_CS, v);
    chk("align_err", {29'd0, v[14:12]}, 32'd3);

    // size error on write
    dmi_wr(A_CS, 32'h0006_7000);
    dmi_wr(A_DATA, 32'h55);
    no_req("size_noreq", 4);
    peek(A_CS, v);
    chk("size_err", {29'd0, v[14:12]}, 32'd4);
    peek(A_DATA, v);
    chk("size_data", v, 32'h55);

    // busy violation
    dmi_wr(A_CS, 32'h0004_7000);
    dmi_wr(A_ADDR, 32'h4000);
    gnt_en = 1'b0;
    push(1'b1, 32'h4000, 32'h1111_1111, 4'hf);
    dmi_wr(A_DATA, 32'h1111_1111);
    @(negedge clk);
    chk("bv_busy", {31'd0, sb_busy}, 32'd1);
    dmi_wr(A_DATA, 32'h2222_2222);
    dmi_rd(A_DATA, v);
    chk("bv_rd", v, 32'h1111_1111);
    gnt_en = 1'b1;
    wait_idle("bv_idle", cyc);
    peek(A_CS, v);
    chk("bv_flag", {31'd0, v[22]}, 32'd1);
    peek(A_DATA, v);
    chk("bv_dropped", v, 32'h1111_1111);
    dmi_wr(A_DATA, 32'h3333_3333);
    no_req("bv_noreq", 4);
    peek(A_DATA, v);
    chk("bv_load", v, 32'h3333_3333);
    dmi_wr(A_CS, 32'h0044_0000);
    peek(A_CS, v);
    chk("bv_w1c", v, 32'h2004_0407);

    // error response
    dmi_wr(A_CS, 32'h0015_0000);
    rsp_err = 1'b1;
    push(1'b0, 32'h5000, 32'd0, 4'hf);
    dmi_wr(A_ADDR, 32'h5000);
    wait_idle("berr_idle", cyc);
    rsp_err = 1'b0;
    peek(A_CS, v);
    chk("berr_err", {29'd0, v[14:12]}, 32'd2);
    peek(A_ADDR, v);
    chk("berr_addr", v, 32'h5000);
    peek(A_DATA, v);
    chk("berr_data", v, 32'h3333_3333);
    dmi_wr(A_CS, 32'h0015_7000);
    peek(A_CS, v);
    chk("berr_clr", v, 32'h2015_0407);

    // auto-increment wrap
    rsp_data = 32'h0BAD_F00D;
    push(1'b0, 32'hFFFF_FFFC, 32'd0, 4'hf);
    dmi_wr(A_ADDR, 32'hFFFF_FFFC);
    wait_idle("wrap_idle", cyc);
    peek(A_ADDR, v);
    chk("wrap_addr", v, 32'd0);
    peek(A_DATA, v);
    chk("wrap_data", v, 32'h0BAD_F00D);

    // 16-bit read from upper half
    dmi_wr(A_CS, 32'h0012_0000);
    rsp_data = 32'hCAFE_1234;
    push(1'b0, 32'h6002, 32'd0, 4'b1100);
    dmi_wr(A_ADDR, 32'h6002);
    wait_idle("rd16_idle", cyc);
    peek(A_DATA, v);
    chk("rd16_data", v, 32'h0000_CAFE);
    peek(A_ADDR, v);
    chk("rd16_addr", v, 32'h6002);

    // timeout behaviour
    dmi_wr(A_CS, 32'h0014_0000);
    gnt_en = 1'b0;
`ifdef SBA_TIMEOUT_EN
    dmi_wr(A_ADDR, 32'h7000);
    cyc = 0;
    while (bus_req && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", cyc, 8);
    chk("tmo_busy", {31'd0, sb_busy}, 32'd0);
    peek(A_CS, v);
    chk("tmo_err", {29'd0, v[14:12]}, 32'd1);
    dmi_wr(A_CS, 32'h0014_7000);
`else
    push(1'b0, 32'h7000, 32'd0, 4'hf);
    dmi_wr(A_ADDR, 32'h7000);
    repeat (20) @(negedge clk);
    chk("notmo_busy", {31'd0, sb_busy}, 32'd1);
    chk("notmo_req", {31'd0, bus_req}, 32'd1);
    gnt_en = 1'b1;
    wait_idle("notmo_idle", cyc);
    peek(A_CS, v);
    chk("notmo_err", {29'd0, v[14:12]}, 32'd0);
    gnt_en = 1'b0;
`endif

    // reset during REQ
    dmi_wr(A_CS, 32'h0015_0000);
    dmi_wr(A_ADDR, 32'h8000);
    chk("mid_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, sb_busy}, 32'd0);
    chk("mid_rst_baddr", bus_addr, 32'd0);
    chk("mid_rst_be", {28'd0, bus_be}, 32'd0);
    peek(A_CS, v);
    chk("mid_rst_sbcs", v, 32'h2000_0407);
    peek(A_ADDR, v);
    chk("mid_rst_addr", v, 32'd0);
    peek(A_DATA, v);
    chk("mid_rst_data", v, 32'd0);
    rst = 1'b0;
    gnt_en = 1'b1;
    no_req("post_rst_noreq", 4);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_sba_ctrl.md
Name: dm_sba_ctrl

Overview:
- System Bus Access (SBA) manager for the RISC-V debug module.
- Owns sbcs, sbaddress0 and sbdata0 as seen from the DMI.
- Turns debugger accesses to those registers into single-beat transactions on the 32-bit system bus, with error checking, busy tracking and address auto-increment.
- Sits between the DMI register decode and the system bus interconnect port.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed from request to response before a timeout is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dmi_valid  in  1  one-cycle DMI access strobe
- dmi_write  in  1  1 = write, 0 = read
- dmi_addr  in  8  debug register address; only 0x38 sbcs, 0x39 sbaddress0 and 0x3c sbdata0 are decoded
- dmi_wdata  in  32  write data
- dmi_rdata  out  32  read data, combinational from dmi_addr; 0 for undecoded addresses
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  byte address
- bus_wdata  out  32  write data, lane-replicated
- bus_be  out  4  byte enables
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid
- bus_rdata  in  32  read data
- bus_err  in  1  error response, qualified by bus_rvalid
- sb_busy  out  1  mirror of sbcs.busy

Behaviour:
- Reset: state IDLE; sbaddress0, sbdata0, busyerror, readonaddr, access, autoincrement, readondata all 0; error = sbe_none; timeout counter 0; bus_req, bus_we, sb_busy = 0; bus_addr, bus_wdata, bus_be = 0.
- sbcs read value (sbcs_t): version = sbv_1_0, size = 32, access32/16/8 = 1, access64/128 = 0, remaining fields from registers.
- sbcs write:
  - busyerror is W1C.
  - error is W1C, applied per bit.
  - readonaddr, access, autoincrement and readondata load directly.
  - Accepted while busy.
- Busy violation: any sbaddress0 or sbdata0 access (read or write) while busy sets busyerror and has no other effect; a read returns the current sbdata0.
- Access start conditions; "errors clear" means busyerror = 0 and error = sbe_none:
  - sbaddress0 write loads the address; if readonaddr and errors clear, start a read.
  - sbdata0 write loads data; if errors clear, start a write.
  - sbdata0 read returns the current value; if readondata and errors clear, start a read.
- Start checks, made in the DMI cycle:
  - access > sba_32bit: error = sbe_size (4), no bus operation.
  - Misaligned address (16-bit with addr[0] = 1, or 32-bit with addr[1:0] != 0): error = sbe_alignment (3), no bus operation.
- FSM states IDLE, REQ, RESP:
  - IDLE -> REQ in the cycle after a valid start. busy = 1 in REQ and RESP.
  - REQ: bus_req = 1 with stable bus_we/addr/wdata/be until bus_gnt, then -> RESP. A gnt in the first REQ cycle is legal.
  - RESP: wait for bus_rvalid, then -> IDLE.
  - Minimum latency from DMI strobe to busy clear is 3 cycles.
- Lanes:
  - bus_be: 8-bit = 4'b0001 << addr[1:0]; 16-bit = 4'b0011 << addr[1:0]; 32-bit = 4'b1111.
  - bus_wdata: 8-bit = byte replicated 4x; 16-bit = half replicated 2x; 32-bit = data unchanged.
  - Read data is extracted from the addressed lane and zero-extended into sbdata0.
- Completion:
  - bus_err = 1: error = sberr_address (2); sbdata0 and address unchanged.
  - Otherwise: a read updates sbdata0; if autoincrement, address += 1/2/4 per the access size, wrapping modulo 2^32.
- Simultaneous events:
  - A DMI access in the completion cycle sees busy = 1 and flags busyerror.
  - An sbcs write to the error field in the same cycle as an error-setting completion: the set wins.
- bus_rvalid or bus_gnt in IDLE is ignored.
- rst mid-transaction: bus_req drops the next cycle, all state returns to its reset value, and any late response is ignored.

Optional Feature:
- Macro: SBA_TIMEOUT_EN.
- Defined:
  - Counter clears on leaving IDLE and counts each cycle in REQ/RESP.
  - On reaching TIMEOUT_CYCLES: bus_req drops, error = sbe_timeout (1), FSM -> IDLE, no increment, sbdata0 unchanged.
- Undefined: no counter; the FSM waits indefinitely and sbe_timeout is never produced.

Test Plan:
- 32-bit read: sbcs.access = 2, readonaddr = 1, then write sbaddress0 = 0x1000; respond rdata = 0xDEADBEEF -> bus_addr = 0x1000, bus_be = 4'hF, bus_we = 0; sbdata0 = 0xDEADBEEF; busy clears 3 cycles after the strobe at minimum latency.
- 8-bit write with auto-increment: access = 0, autoincrement = 1, sbaddress0 = 0x2003, sbdata0 write = 0xA5 -> bus_be = 4'b1000, bus_wdata = 0xA5A5A5A5; sbaddress0 becomes 0x2004.
- Misaligned and size errors: 16-bit access with sbaddress0 = 0x3001 and readonaddr = 1 -> error = 3, no bus_req. Clear error, set access = 3, write sbdata0 -> error = 4, no bus_req.
- Busy violation: withhold gnt, write sbdata0 again -> busyerror = 1 and the second write is dropped; after completion, a further sbdata0 write starts nothing until busyerror is cleared via W1C.
- Error and wrap: bus_err response -> error = 2 and address unchanged; autoincrement 32-bit read at 0xFFFFFFFC -> address wraps to 0x00000000.
- Timeout and reset (SBA_TIMEOUT_EN, TIMEOUT_CYCLES = 8): never grant -> error = 1 and bus_req low after 8 cycles; a separate run asserting rst during REQ -> bus_req = 0 and all registers at reset values the next cycle.
